// File: rtl/control_main_fsm_if.sv
// Control bundle between the main FSM and the datapath.
// Instruction fields and Zero flow in, control strobes flow out.
interface control_main_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       IllegalOp;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output ResultSrc, ALUSrcA, ALUSrcB,
    output ALUControl, ImmSrc, RegWrite, IllegalOp
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB,
    input  ALUControl, ImmSrc, RegWrite, IllegalOp
  );
endinterface

// File: rtl/control_main_fsm.sv
// Multicycle main control FSM with ALU and immediate decoders.
// Moore outputs from state; PCWrite, ALUControl, ImmSrc mix inputs.
module control_main_fsm (
  input  logic                       clk,
  input  logic                       reset,
  control_main_fsm_if.master         bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0] state;
  logic [3:0] next;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       is_lw;
  logic       is_sw;
  logic       is_r;
  logic       is_i;
  logic       is_jal;
  logic       is_beq;

  assign is_lw  = (bus.op == OP_LW);
  assign is_sw  = (bus.op == OP_SW);
  assign is_r   = (bus.op == OP_R);
  assign is_i   = (bus.op == OP_I);
  assign is_jal = (bus.op == OP_JAL);
  assign is_beq = (bus.op == OP_BEQ);

  // State register; reset wins over any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    next = FETCH;
    case (state)
      FETCH: next = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: next = MEMADR;
          is_r:         next = EXECR;
          is_i:         next = EXECI;
          is_jal:       next = JAL;
          is_beq:       next = BEQ;
          default:      next = FETCH;
        endcase
      end
      MEMADR:   next = is_sw ? MEMWRITE : MEMREAD;
      MEMREAD:  next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: next = FETCH;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      JAL:      next = ALUWB;
      BEQ:      next = FETCH;
      default:  next = FETCH;
    endcase
  end

  // Moore control outputs decoded from the current state
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = 2'b00;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.IllegalOp = 1'b0;
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        pc_update     = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b01;
        bus.IllegalOp = ~(is_lw | is_sw | is_r |
                          is_i | is_jal | is_beq);
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b10;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = 2'b10;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pc_update   = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite = pc_update | (branch & bus.Zero);

  // ALU decoder; subtract only for R-type with funct7b5 set
  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      2'b01: bus.ALUControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000: bus.ALUControl =
            (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010: bus.ALUControl = 3'b101;
          3'b110: bus.ALUControl = 3'b011;
          3'b111: bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
      default: bus.ALUControl = 3'b000;
    endcase
  end

  // Immediate format select from opcode, independent of state
  always_comb begin
    bus.ImmSrc = 2'b00;
    unique case (1'b1)
      is_sw:   bus.ImmSrc = 2'b01;
      is_beq:  bus.ImmSrc = 2'b10;
      is_jal:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_control_main_fsm.sv
// Directed bench for control_main_fsm.
// Checks the full control word every cycle of each instruction.
module tb_control_main_fsm;

  localparam int S_FETCH    = 0;
  localparam int S_DECODE   = 1;
  localparam int S_MEMADR   = 2;
  localparam int S_MEMREAD  = 3;
  localparam int S_MEMWB    = 4;
  localparam int S_MEMWRITE = 5;
  localparam int S_EXECR    = 6;
  localparam int S_EXECI    = 7;
  localparam int S_ALUWB    = 8;
  localparam int S_JAL      = 9;
  localparam int S_BEQ      = 10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  control_main_fsm_if bus ();

  control_main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,
  //  ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,IllegalOp}
  function automatic logic [16:0] ev(
    input int         s,
    input logic [2:0] alu,
    input logic [1:0] imm,
    input logic       z,
    input logic       il
  );
    logic       pcw, adr, mw, ir, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] a;
    pcw = 0; adr = 0; mw = 0; ir = 0; rw = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; a = 3'b000;
    case (s)
      S_FETCH: begin
        pcw = 1; ir = 1; sb = 2'b10; rs = 2'b10;
      end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    begin sa = 2'b10; a = alu; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; a = alu; end
      S_ALUWB:    rw = 1;
      S_JAL:      begin pcw = 1; sa = 2'b01; sb = 2'b10; end
      S_BEQ:      begin pcw = z; sa = 2'b10; a = 3'b001; end
      default: ;
    endcase
    return {pcw, adr, mw, ir, rs, sa, sb, a, imm, rw, il};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite,
            bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
            bus.RegWrite, bus.IllegalOp};
  endfunction

  task automatic check(input string tag, input logic [16:0] e);
    logic [16:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [16:0] e);
    @(negedge clk);
    #1;
    check(tag, e);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.op       = OP_R;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b1;
    bus.Zero     = 1'b0;

    step("rst_c1", ev(S_FETCH, 0, 2'b00, 0, 0));
    step("rst_c2", ev(S_FETCH, 0, 2'b00, 0, 0));
    reset = 1'b0;
    step("r_sub_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("r_sub_ex", ev(S_EXECR, 3'b001, 2'b00, 0, 0));
    step("r_sub_wb", ev(S_ALUWB, 0, 2'b00, 0, 0));
    step("r_sub_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.op = OP_LW;
    #1;
    check("lw_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));
    step("lw_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("lw_adr", ev(S_MEMADR, 0, 2'b00, 0, 0));
    step("lw_rd", ev(S_MEMREAD, 0, 2'b00, 0, 0));
    step("lw_wb", ev(S_MEMWB, 0, 2'b00, 0, 0));
    step("lw_fetch2", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.op = OP_SW;
    #1;
    check("sw_fetch", ev(S_FETCH, 0, 2'b01, 0, 0));
    step("sw_dec", ev(S_DECODE, 0, 2'b01, 0, 0));
    step("sw_adr", ev(S_MEMADR, 0, 2'b01, 0, 0));
    step("sw_wr", ev(S_MEMWRITE, 0, 2'b01, 0, 0));
    step("sw_fetch2", ev(S_FETCH, 0, 2'b01, 0, 0));

    bus.op   = OP_BEQ;
    bus.Zero = 1'b1;
    #1;
    check("beq1_fetch", ev(S_FETCH, 0, 2'b10, 1, 0));
    step("beq1_dec", ev(S_DECODE, 0, 2'b10, 1, 0));
    step("beq1_br", ev(S_BEQ, 0, 2'b10, 1, 0));
    step("beq1_fetch2", ev(S_FETCH, 0, 2'b10, 1, 0));

    bus.Zero = 1'b0;
    step("beq0_dec", ev(S_DECODE, 0, 2'b10, 0, 0));
    step("beq0_br", ev(S_BEQ, 0, 2'b10, 0, 0));
    step("beq0_fetch2", ev(S_FETCH, 0, 2'b10, 0, 0));

    bus.op     = OP_R;
    bus.funct3 = 3'b111;
    step("and_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("and_ex", ev(S_EXECR, 3'b010, 2'b00, 0, 0));
    step("and_wb", ev(S_ALUWB, 0, 2'b00, 0, 0));
    step("and_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.funct3 = 3'b110;
    step("or_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("or_ex", ev(S_EXECR, 3'b011, 2'b00, 0, 0));
    step("or_wb", ev(S_ALUWB, 0, 2'b00, 0, 0));
    step("or_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.funct3 = 3'b010;
    step("slt_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("slt_ex", ev(S_EXECR, 3'b101, 2'b00, 0, 0));
    step("slt_wb", ev(S_ALUWB, 0, 2'b00, 0, 0));
    step("slt_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.op       = OP_I;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b1;
    step("addi_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("addi_ex", ev(S_EXECI, 3'b000, 2'b00, 0, 0));
    step("addi_wb", ev(S_ALUWB, 0, 2'b00, 0, 0));
    step("addi_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.op = OP_JAL;
    step("jal_dec", ev(S_DECODE, 0, 2'b11, 0, 0));
    step("jal_jmp", ev(S_JAL, 0, 2'b11, 0, 0));
    step("jal_wb", ev(S_ALUWB, 0, 2'b11, 0, 0));
    step("jal_fetch", ev(S_FETCH, 0, 2'b11, 0, 0));

    bus.op = OP_BAD;
    step("ill_dec", ev(S_DECODE, 0, 2'b00, 0, 1));
    step("ill_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));

    bus.op = OP_LW;
    step("mrst_dec", ev(S_DECODE, 0, 2'b00, 0, 0));
    step("mrst_adr", ev(S_MEMADR, 0, 2'b00, 0, 0));
    step("mrst_rd", ev(S_MEMREAD, 0, 2'b00, 0, 0));
    reset = 1'b1;
    step("mrst_fetch", ev(S_FETCH, 0, 2'b00, 0, 0));
    reset = 1'b0;
    step("mrst_dec2", ev(S_DECODE, 0, 2'b00, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_main_fsm.md
# control_main_fsm

Multicycle control unit that drives the datapath one instruction at a time. It produces IRWrite during Fetch so the instruction register captures RD and OldPC together at the end of that cycle. It then decodes the captured opcode and sequences the address, memory, execute and writeback steps for lw, sw, R-type, I-type ALU, jal and beq. It also contains the ALU decoder and the immediate-select decoder.

## Interface
- No parameters.
- clk  input  1  rising-edge clock, shared with the instruction register
- reset  input  1  synchronous, active-high; forces state to FETCH at the next edge
- op  input  7  Instr[6:0] from the instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register / OldPC enable
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A (RD1)
- ALUSrcB  output  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  output  1  register file write enable
- IllegalOp  output  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- Opcodes:
  - lw = 0000011
  - sw = 0100011
  - R-type = 0110011
  - I-type ALU = 0010011
  - jal = 1101111
  - beq = 1100011
- State register with 11 states. The only sequential element is the state register.
- All outputs are combinational (Moore) from the state. The exceptions are:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ALUControl and ImmSrc also depend on op, funct3 and funct7b5.
- Every output not listed for a state is 0. Every 2-bit select not listed is 00.
- States, asserted outputs, and next state:
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next by op:
    - lw or sw -> MEMADR
    - R-type -> EXECR
    - I-type -> EXECI
    - jal -> JAL
    - beq -> BEQ
    - any other op -> FETCH, with IllegalOp=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Next: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Next: FETCH.
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10 decodes on funct3:
    - 000 -> sub if (op[5] & funct7b5), otherwise add.
    - 010 -> slt.
    - 110 -> or.
    - 111 -> and.
    - any other funct3 -> add.
- ImmSrc is decoded from op in every state:
  - lw and I-type -> 00.
  - sw -> 01.
  - beq -> 10.
  - jal -> 11.
  - any other op -> 00.
- Unreachable state encodings -> next state FETCH.

## Timing
- Reset: state = FETCH at the first edge with reset=1. Reset dominates every transition, including mid-instruction.
  - While in FETCH after reset: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcB=10, ResultSrc=10.
  - MemWrite=0 and RegWrite=0.
  - IllegalOp=0.
- IRWrite is high only in FETCH and lasts exactly one cycle per instruction. Instr and OldPC are valid from the DECODE cycle onward.
- op is only meaningful from DECODE onward. FETCH outputs do not depend on op, except ImmSrc and ALUControl, which are unused in FETCH.
- Latency in cycles, FETCH to the next FETCH:
  - lw = 5
  - sw = 4
  - R-type = 4
  - I-type = 4
  - jal = 4
  - beq = 3
  - illegal = 2
- MemWrite pulses for exactly one cycle per sw. RegWrite pulses for exactly one cycle per lw, R-type, I-type and jal. beq never asserts RegWrite.
- beq: PCWrite equals Zero during the BEQ cycle.
- There is no stall input. The block advances every cycle.

## Test plan
- Reset held for 2 cycles, then released with op=0110011:
  - During reset: FETCH outputs, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0.
  - After release: sequence FETCH, DECODE, EXECR, ALUWB, FETCH.
- lw (op=0000011):
  - Sequence: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - AdrSrc=1 in MEMREAD.
  - RegWrite=1 with ResultSrc=01 only in MEMWB.
  - ImmSrc=00 throughout.
- sw (op=0100011): MemWrite=1 in exactly one cycle (cycle 4), ImmSrc=01, RegWrite never asserted.
- beq (op=1100011, funct3=000):
  - With Zero=1 in BEQ: PCWrite=1 and ALUControl=001.
  - Repeat with Zero=0: PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- R-type decodes in EXECR:
  - funct3=000, funct7b5=1 -> 001 (sub).
  - funct3=111 -> 010 (and).
  - funct3=110 -> 011 (or).
  - funct3=010 -> 101 (slt).
  - I-type addi with funct7b5=1 -> 000 (add).
- Edge cases:
  - op=1111111: IllegalOp=1 in DECODE, then FETCH.
  - reset asserted during MEMREAD: FETCH at the next edge, no RegWrite pulse.
